count_checker: RTL and testbench
================================

# count_checker

Passive sequence checker for the free-running up-counter's `value` bus. It samples the count every clock and locks onto the +1 sequence. It then reports wrap-arounds, counter restarts (returns to zero) and sequence errors, with saturating event counters. It sits beside the counter in simulation benches and on-chip debug paths; it never drives the counter.

## Interface
- `WIDTH`, 8: width of the observed count.
- `LOCK_CYCLES`, 4: consecutive +1 steps required to lock (1..255).
- `ERR_W`, 16: width of `err_count`.
- `WRAP_W`, 16: width of `wrap_count`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `value` input WIDTH: observed count, sampled every rising edge.
- `locked` output 1: checker is in LOCKED.
- `error` output 1: one-cycle pulse on a sequence error.
- `restart` output 1: one-cycle pulse when the count returns to 0 unexpectedly.
- `wrap` output 1: one-cycle pulse on the max→0 step.
- `err_count` output ERR_W: saturating count of `error` pulses.
- `wrap_count` output WRAP_W: saturating count of `wrap` pulses.

## Operation
- Registers:
  - `prev` holds the last sample.
  - `have_prev` is cleared by reset and set after the first sample.
  - `run` (8 bits) counts consecutive good steps.
- `exp = prev + 1`, computed modulo 2^WIDTH, so max+1 = 0.
- States: ACQUIRE, LOCKED, FAULT.
- ACQUIRE:
  - The first sample after reset only loads `prev`.
  - After that, each cycle: `value == exp` → `run++`; anything else → `run = 0`.
  - When `run` reaches LOCK_CYCLES → LOCKED.
  - No flags assert in ACQUIRE.
- LOCKED, evaluated in priority order:
  - `value == exp` and `prev == max` → `wrap` pulse and `wrap_count++`.
  - `value == exp` → no flag.
  - `value == 0` → `restart` pulse; stay LOCKED. This covers a held reset where `prev == 0` and `value == 0`; `restart` pulses only on the first such cycle.
  - Anything else → `error` pulse, `err_count++`, go to FAULT, `run = 0`.
- FAULT: `locked` is 0 and no further `error` pulses are produced. Exit behaviour is set by the macro under Configuration.
- `prev` loads `value` every cycle in every state.
- Saturating counters hold at all-ones; they never wrap.
- Reset is asynchronous and clears everything immediately, mid-sequence included. After reset: state = ACQUIRE, `locked` = 0, `error` = 0, `restart` = 0, `wrap` = 0, `err_count` = 0, `wrap_count` = 0, `prev` = 0, `have_prev` = 0, `run` = 0.

## Timing
- All outputs are registered.
- A sample taken at edge N produces its flags and counter updates at edge N, visible until edge N+1. Latency is one cycle from `value` changing.
- Lock time: first sample, then LOCK_CYCLES good steps. `locked` rises at the edge of the last good step.
- The LOCKED→FAULT transition and the `error` pulse occur on the same edge; `locked` falls on that edge.
- A saturated counter still pulses its flag.

## Configuration
- `COUNT_CHECKER_RESYNC_EN` defined:
  - FAULT behaves like ACQUIRE: `run` counts good steps from the faulting sample.
  - After LOCK_CYCLES good steps the checker relocks and `locked` rises.
  - `err_count` is preserved across the relock.
- Not defined: FAULT is sticky; only `reset` leaves it.

## Structure
- Package `count_checker_pkg`: `state_t` enum {ACQUIRE, LOCKED, FAULT} and a `RUN_W = 8` constant.
- One sub-module, `sat_counter` (parameter W; inputs `clk`, `reset`, `inc`; output `q`), instantiated for `err_count` and `wrap_count`.

## Test plan
1. **Lock, no errors.** Reset for 3 cycles, release, counter counts 0,1,2,3,4,5 → `locked` rises at the edge sampling 4. `error`, `wrap` and `restart` stay 0.
2. **Wrap.** Locked with WIDTH=8, counter steps 0xFE,0xFF,0x00 → single `wrap` pulse on the 0x00 sample; `wrap_count` = 1; `locked` stays 1.
3. **Counter restart.** Locked at 0x25, counter reset held for 5 cycles (value 0), then counts 1,2 → one `restart` pulse; `error` = 0; `locked` stays 1.
4. **Skip error.** Locked at 0x10, then value 0x12 → `error` pulse and `err_count` = 1; `locked` falls.
   - Without the macro: the count continues 0x13..0x20 and `locked` stays 0.
   - With the macro: `locked` rises again 4 good steps later.
5. **Saturation.** ERR_W=2 with the macro defined, inject 5 errors, each followed by a relock → `err_count` holds 3 while `error` still pulses 5 times.
6. **Async reset mid-lock.** Assert `reset` between clock edges while LOCKED → all outputs go to 0 immediately, before the next edge. After release, relock follows the scenario 1 timing.

Source files
------------

// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared state encoding and run-counter width for count_checker.
package count_checker_pkg;
    typedef enum logic [1:0] {ACQUIRE, LOCKED, FAULT} state_t;
    localparam int RUN_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/count_checker.sv
// count_checker: passive +1 sequence checker reporting wrap, restart and sequence errors.
// COUNT_CHECKER_RESYNC_EN lets FAULT reacquire and relock; otherwise FAULT is sticky until reset.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_W       = 16,
    parameter int WRAP_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  value,
    output logic              locked,
    output logic              error,
    output logic              restart,
    output logic              wrap,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count
);
`ifdef COUNT_CHECKER_RESYNC_EN
    localparam logic RESYNC = 1'b1;
`else
    localparam logic RESYNC = 1'b0;
`endif
    localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_CYCLES);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  prev, exp;
    logic              have_prev;
    logic [RUN_W-1:0]  run, run_nxt, run_inc;
    logic              good, error_nxt, restart_nxt, wrap_nxt;

    assign exp     = prev + 1'b1;
    assign good    = have_prev && value == exp;
    assign run_inc = run + 1'b1;
    assign locked  = state == LOCKED;

    always_comb begin
        state_nxt   = state;
        run_nxt     = run;
        error_nxt   = 1'b0;
        restart_nxt = 1'b0;
        wrap_nxt    = 1'b0;
        case (state)
            LOCKED:
                if (value == exp) wrap_nxt = prev == '1;
                // a held counter reset repeats 0; only the first zero is a restart
                else if (value == '0) restart_nxt = prev != '0;
                else begin
                    error_nxt = 1'b1;
                    state_nxt = FAULT;
                    run_nxt   = '0;
                end
            default:
                if (have_prev && (state == ACQUIRE || RESYNC)) begin
                    run_nxt = good ? run_inc : '0;
                    if (good && run_inc >= LOCK_N) state_nxt = LOCKED;
                end
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= ACQUIRE;
            prev      <= '0;
            have_prev <= 1'b0;
            run       <= '0;
            error     <= 1'b0;
            restart   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= value;
            have_prev <= 1'b1;
            run       <= run_nxt;
            error     <= error_nxt;
            restart   <= restart_nxt;
            wrap      <= wrap_nxt;
        end

    sat_counter #(.W(ERR_W)) u_err (.clk(clk), .reset(reset), .inc(error_nxt), .q(err_count));
    sat_counter #(.W(WRAP_W)) u_wrap (.clk(clk), .reset(reset), .inc(wrap_nxt), .q(wrap_count));
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: table-driven and hand-sequenced checks of count_checker (WRAP_W=2 to reach saturation).
module tb_count_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  value = 8'h00;
    logic        locked, error, restart, wrap;
    logic [15:0] err_count;
    logic [1:0]  wrap_count;
    int          tests = 0;
    int          fails = 0;

    count_checker #(.WIDTH(8), .LOCK_CYCLES(4), .ERR_W(16), .WRAP_W(2)) dut (
        .clk(clk), .reset(reset), .value(value), .locked(locked), .error(error),
        .restart(restart), .wrap(wrap), .err_count(err_count), .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  v;
        logic        l, e, r, w;
        logic [15:0] ec;
        logic [1:0]  wc;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic rst, input logic [7:0] v, input logic l, input logic e,
                       input logic r, input logic w, input logic [15:0] ec, input logic [1:0] wc);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.e = e; t.r = r; t.w = w; t.ec = ec; t.wc = wc;
        tv.push_back(t);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", n, got, want);
        end
    endtask

    task automatic chk_out(input string n, input logic l, input logic e, input logic r,
                           input logic w, input logic [15:0] ec, input logic [1:0] wc);
        chk(n, {10'd0, locked, error, restart, wrap, err_count, wrap_count},
               {10'd0, l, e, r, w, ec, wc});
    endtask

    task automatic step(input logic [7:0] v);
        value = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // lock, no errors
        for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'(i), i >= 4, 0, 0, 0, 0, 0);
        // restart while locked
        add(1, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'(8'h20 + i), i >= 4, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        add(0, 8'h01, 1, 0, 0, 0, 0, 0);
        add(0, 8'h02, 1, 0, 0, 0, 0, 0);
        // skip error
        add(1, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 8'(8'h0C + i), i >= 4, 0, 0, 0, 0, 0);
        add(0, 8'h12, 0, 1, 0, 0, 1, 0);

        @(posedge clk); #1;
        chk_out("reset_state", 0, 0, 0, 0, 0, 0);
        foreach (tv[i]) begin
            reset = tv[i].rst;
            step(tv[i].v);
            chk_out($sformatf("vec%0d", i), tv[i].l, tv[i].e, tv[i].r, tv[i].w, tv[i].ec, tv[i].wc);
        end

        for (int v = 8'h13; v <= 8'h20; v++) begin
            step(8'(v));
`ifdef COUNT_CHECKER_RESYNC_EN
            chk_out($sformatf("post_err_%0h", v), v >= 8'h16, 0, 0, 0, 1, 0);
`else
            chk_out($sformatf("post_err_%0h", v), 0, 0, 0, 0, 1, 0);
`endif
        end

        // wrap
        reset = 1'b1;
        step(8'h00);
        reset = 1'b0;
        for (int v = 8'hF0; v <= 8'hFF; v++) step(8'(v));
        chk_out("pre_wrap", 1, 0, 0, 0, 0, 0);
        step(8'h00);
        chk_out("wrap", 1, 0, 0, 1, 0, 1);
        step(8'h01);
        chk_out("after_wrap", 1, 0, 0, 0, 0, 1);

        // wrap_count saturation at 3 while wrap keeps pulsing
        begin
            int pulses = 1;
            for (int n = 2; n <= 5; n++) begin
                for (int k = 2; k < 256; k++) begin
                    step(8'(k));
                    if (wrap) pulses++;
                end
                step(8'h00);
                if (wrap) pulses++;
                chk_out($sformatf("wrap_sat%0d", n), 1, 0, 0, 1, 0, n > 3 ? 2'd3 : 2'(n));
                step(8'h01);
                if (wrap) pulses++;
            end
            chk("wrap_pulses", pulses, 5);
        end

        // async reset between edges
        value = 8'h02;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_out("async_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(8'(i));
            chk_out($sformatf("relock%0d", i), i >= 4, 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
